// File: rtl/router_pkg.sv
// Shared types and helpers for the parametrised router control FSM and its
// per-channel soft-reset timeout counters.
package router_pkg;

  // Nine control states; a 4-bit encoding leaves room for future states.
  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    LOAD_PARITY        = 4'd3,
    FIFO_FULL_STATE    = 4'd4,
    LOAD_AFTER_FULL    = 4'd5,
    WAIT_TILL_EMPTY    = 4'd6,
    CHECK_PARITY_ERROR = 4'd7,
    DROP_PACKET        = 4'd8
  } router_state_t;

  localparam int STATE_W = 4;

  // Width of a timeout counter that must hold values 0 .. timeout-1.
  function automatic int ctr_width(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/router_timeout_ctr.sv
// Idle-read watchdog for one output FIFO: if the FIFO stays non-empty and
// unread for TIMEOUT consecutive cycles, emit a one-cycle soft_reset pulse.
module router_timeout_ctr
  import router_pkg::*;
#(
  parameter int TIMEOUT = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic empty,
  input  logic read_enb,
  output logic soft_reset
);

  localparam int            CW   = ctr_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count;

  // Count unread non-empty cycles; on reaching the limit fire the pulse and restart from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      soft_reset <= 1'b0;
    end else if (empty || read_enb) begin
      count      <= '0;
      soft_reset <= 1'b0;
    end else if (count == LAST) begin
      count      <= '0;
      soft_reset <= 1'b1;
    end else begin
      count      <= count + ONE;
      soft_reset <= 1'b0;
    end
  end

endmodule

// File: rtl/router_fsm_nch.sv
// Router control FSM for NUM_CH output FIFOs. Steers a byte-serial packet
// into the FIFO addressed by its header, sequences header/payload/parity
// loads, stalls on FIFO-full, drops packets to nonexistent channels and
// owns the per-channel soft-reset watchdogs.
module router_fsm_nch
  import router_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_valid,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic [NUM_CH-1:0] fifo_full_vec,
  input  logic [NUM_CH-1:0] fifo_empty_vec,
  input  logic [NUM_CH-1:0] read_enb_vec,
  output logic              busy,
  output logic              detect_addr,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic              drop_state,
  output logic [NUM_CH-1:0] write_enb,
  output logic [NUM_CH-1:0] soft_reset
);

  // One extra bit so NUM_CH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] NUM_CH_LIM = (ADDR_W + 1)'(NUM_CH);

  router_state_t     state;
  router_state_t     state_nxt;
  logic [ADDR_W-1:0] sel;
  logic [ADDR_W-1:0] sel_nxt;

  logic              addr_ok;
  logic              empty_at_addr;
  logic              full;
  logic              empty_sel;
  logic              sr_sel;
  logic [NUM_CH-1:0] sel_onehot;
  logic              writes_nxt;

  // One watchdog per channel, running regardless of what the FSM is doing.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_timeout
    router_timeout_ctr #(
      .TIMEOUT(TIMEOUT)
    ) u_ctr (
      .clk       (clk),
      .rst       (rst),
      .empty     (fifo_empty_vec[g]),
      .read_enb  (read_enb_vec[g]),
      .soft_reset(soft_reset[g])
    );
  end

  // Per-channel lookups for the header address and the latched channel; out-of-range addresses read as 0.
  always_comb begin
    addr_ok       = ({1'b0, data_in} < NUM_CH_LIM);
    empty_at_addr = 1'b0;
    full          = 1'b0;
    empty_sel     = 1'b0;
    sr_sel        = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (data_in == ADDR_W'(i)) begin
        empty_at_addr = fifo_empty_vec[i];
      end
      if (sel == ADDR_W'(i)) begin
        full      = fifo_full_vec[i];
        empty_sel = fifo_empty_vec[i];
        sr_sel    = soft_reset[i];
      end
    end
  end

  // Next-state and next-channel selection; a soft reset of the active channel aborts any packet in flight.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    if ((state == DECODE_ADDRESS) && pkt_valid && addr_ok) begin
      sel_nxt = data_in;
    end
    if ((state != DECODE_ADDRESS) && sr_sel) begin
      state_nxt = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (pkt_valid) begin
            if (!addr_ok)          state_nxt = DROP_PACKET;
            else if (empty_at_addr) state_nxt = LOAD_FIRST_DATA;
            else                    state_nxt = WAIT_TILL_EMPTY;
          end
        end
        LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
        LOAD_DATA: begin
          if (full)            state_nxt = FIFO_FULL_STATE;
          else if (!pkt_valid) state_nxt = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!full) state_nxt = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)        state_nxt = DECODE_ADDRESS;
          else if (low_pkt_valid) state_nxt = LOAD_PARITY;
          else                    state_nxt = LOAD_DATA;
        end
        LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          if (full) state_nxt = FIFO_FULL_STATE;
          else      state_nxt = DECODE_ADDRESS;
        end
        WAIT_TILL_EMPTY: begin
          if (empty_sel) state_nxt = LOAD_FIRST_DATA;
        end
        DROP_PACKET: begin
          if (!pkt_valid) state_nxt = DECODE_ADDRESS;
        end
        default: state_nxt = DECODE_ADDRESS;
      endcase
    end
  end

  // One-hot of the channel that will be selected next cycle, and whether that state writes it.
  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_onehot[i] = (sel_nxt == ADDR_W'(i));
    end
    writes_nxt = (state_nxt == LOAD_FIRST_DATA) || (state_nxt == LOAD_DATA) ||
                 (state_nxt == LOAD_PARITY)     || (state_nxt == LOAD_AFTER_FULL);
  end

  // State register with outputs decoded from the next state, so every output is a flop yet tracks the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= DECODE_ADDRESS;
      sel           <= '0;
      detect_addr   <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      laf_state     <= 1'b0;
      full_state    <= 1'b0;
      rst_int_reg   <= 1'b0;
      drop_state    <= 1'b0;
      write_enb_reg <= 1'b0;
      busy          <= 1'b0;
      write_enb     <= '0;
    end else begin
      state         <= state_nxt;
      sel           <= sel_nxt;
      detect_addr   <= (state_nxt == DECODE_ADDRESS);
      lfd_state     <= (state_nxt == LOAD_FIRST_DATA);
      ld_state      <= (state_nxt == LOAD_DATA);
      laf_state     <= (state_nxt == LOAD_AFTER_FULL);
      full_state    <= (state_nxt == FIFO_FULL_STATE);
      rst_int_reg   <= (state_nxt == CHECK_PARITY_ERROR);
      drop_state    <= (state_nxt == DROP_PACKET);
      write_enb_reg <= (state_nxt == LOAD_DATA) || (state_nxt == LOAD_PARITY) ||
                       (state_nxt == LOAD_AFTER_FULL);
      busy          <= (state_nxt == LOAD_FIRST_DATA) || (state_nxt == LOAD_PARITY) ||
                       (state_nxt == FIFO_FULL_STATE) || (state_nxt == LOAD_AFTER_FULL) ||
                       (state_nxt == WAIT_TILL_EMPTY) || (state_nxt == CHECK_PARITY_ERROR);
      write_enb     <= writes_nxt ? sel_onehot : '0;
    end
  end

endmodule

// File: tb/tb_router_fsm_nch.sv
// Bench for router_fsm_nch: directed vector table, hand-written timeout
// sequences and randomized traffic, all checked against a behavioural model.
module tb_router_fsm_nch;

  localparam int NUM_CH  = 3;
  localparam int ADDR_W  = 2;
  localparam int TIMEOUT = 30;

  logic              clk = 1'b0;
  logic              rst;
  logic              pkt_valid;
  logic              parity_done;
  logic              low_pkt_valid;
  logic [ADDR_W-1:0] data_in;
  logic [NUM_CH-1:0] fifo_full_vec;
  logic [NUM_CH-1:0] fifo_empty_vec;
  logic [NUM_CH-1:0] read_enb_vec;
  logic              busy, detect_addr, lfd_state, ld_state, laf_state;
  logic              full_state, write_enb_reg, rst_int_reg, drop_state;
  logic [NUM_CH-1:0] write_enb;
  logic [NUM_CH-1:0] soft_reset;

  int errors = 0;
  int checks = 0;

  // Packet phases as the bench thinks of them.
  typedef enum int {P_IDLE, P_FIRST, P_BODY, P_PARITY, P_STALL, P_RESUME, P_WAIT, P_CHECK, P_DROP} phase_e;

  phase_e            m_phase;
  int                m_sel;
  int                m_cnt [NUM_CH];
  logic [NUM_CH-1:0] m_sr;
  bit                model_valid = 1'b0;

  typedef struct {
    logic              r;
    logic              pv;
    logic [ADDR_W-1:0] din;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] full;
    logic              low;
    logic              pdone;
    phase_e            exp_phase;
    logic [NUM_CH-1:0] exp_we;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  router_fsm_nch #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pkt_valid     (pkt_valid),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .data_in       (data_in),
    .fifo_full_vec (fifo_full_vec),
    .fifo_empty_vec(fifo_empty_vec),
    .read_enb_vec  (read_enb_vec),
    .busy          (busy),
    .detect_addr   (detect_addr),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .write_enb_reg (write_enb_reg),
    .rst_int_reg   (rst_int_reg),
    .drop_state    (drop_state),
    .write_enb     (write_enb),
    .soft_reset    (soft_reset)
  );

  // Output flags in the order {busy, drop, rst_int, wer, full, laf, ld, lfd, detect}.
  function automatic logic [8:0] flagsOf(input phase_e p);
    logic [8:0] f;
    f = '0;
    case (p)
      P_IDLE:   f[0] = 1'b1;
      P_FIRST:  begin f[1] = 1'b1; f[8] = 1'b1; end
      P_BODY:   begin f[2] = 1'b1; f[5] = 1'b1; end
      P_PARITY: begin f[5] = 1'b1; f[8] = 1'b1; end
      P_STALL:  begin f[4] = 1'b1; f[8] = 1'b1; end
      P_RESUME: begin f[3] = 1'b1; f[5] = 1'b1; f[8] = 1'b1; end
      P_WAIT:   f[8] = 1'b1;
      P_CHECK:  begin f[6] = 1'b1; f[8] = 1'b1; end
      P_DROP:   f[7] = 1'b1;
      default:  f = '0;
    endcase
    return f;
  endfunction

  function automatic logic [NUM_CH-1:0] weOf(input phase_e p, input int sel);
    logic [NUM_CH-1:0] w;
    w = '0;
    if (p == P_FIRST || p == P_BODY || p == P_PARITY || p == P_RESUME) w[sel] = 1'b1;
    return w;
  endfunction

  function automatic vec_t mk(input logic r, input logic pv, input int din,
                              input logic [NUM_CH-1:0] e, input logic [NUM_CH-1:0] f,
                              input logic lo, input logic pd, input phase_e p,
                              input logic [NUM_CH-1:0] we);
    vec_t v;
    v.r = r; v.pv = pv; v.din = ADDR_W'(din); v.empty = e; v.full = f;
    v.low = lo; v.pdone = pd; v.exp_phase = p; v.exp_we = we;
    return v;
  endfunction

  // Advance the reference model by one clock edge using the inputs seen at that edge.
  task automatic modelStep();
    phase_e nx;
    logic   full_s, emp_s;
    int     a;
    if (rst) begin
      m_phase = P_IDLE;
      m_sel   = 0;
      m_sr    = '0;
      for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
      model_valid = 1'b1;
    end else begin
      a      = int'(data_in);
      nx     = m_phase;
      full_s = fifo_full_vec[m_sel];
      emp_s  = fifo_empty_vec[m_sel];
      if (m_phase != P_IDLE && m_sr[m_sel]) nx = P_IDLE;
      else begin
        case (m_phase)
          P_IDLE: if (pkt_valid) begin
            if (a >= NUM_CH) nx = P_DROP;
            else begin
              m_sel = a;
              nx = fifo_empty_vec[a] ? P_FIRST : P_WAIT;
            end
          end
          P_FIRST:  nx = P_BODY;
          P_BODY:   nx = full_s ? P_STALL : (!pkt_valid ? P_PARITY : P_BODY);
          P_STALL:  nx = full_s ? P_STALL : P_RESUME;
          P_RESUME: nx = parity_done ? P_IDLE : (low_pkt_valid ? P_PARITY : P_BODY);
          P_PARITY: nx = P_CHECK;
          P_CHECK:  nx = full_s ? P_STALL : P_IDLE;
          P_WAIT:   nx = emp_s ? P_FIRST : P_WAIT;
          P_DROP:   nx = pkt_valid ? P_DROP : P_IDLE;
          default:  nx = P_IDLE;
        endcase
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (fifo_empty_vec[i] || read_enb_vec[i]) begin
          m_cnt[i] = 0; m_sr[i] = 1'b0;
        end else if (m_cnt[i] == TIMEOUT - 1) begin
          m_cnt[i] = 0; m_sr[i] = 1'b1;
        end else begin
          m_cnt[i]++; m_sr[i] = 1'b0;
        end
      end
      m_phase = nx;
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [8:0] flags;
    flags = {busy, drop_state, rst_int_reg, write_enb_reg, full_state,
             laf_state, ld_state, lfd_state, detect_addr};
    if (model_valid) begin
      checkValue({tag, "_flags"}, 32'(flags), 32'(flagsOf(m_phase)));
      checkValue({tag, "_write_enb"}, 32'(write_enb), 32'(weOf(m_phase, m_sel)));
      checkValue({tag, "_soft_reset"}, 32'(soft_reset), 32'(m_sr));
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then let the rising edge happen and compare against the model.
  task automatic applyStimulus(input logic r, input logic pv, input logic [ADDR_W-1:0] din,
                               input logic [NUM_CH-1:0] e, input logic [NUM_CH-1:0] f,
                               input logic lo, input logic pd, input logic [NUM_CH-1:0] rd,
                               input string tag);
    @(negedge clk);
    rst = r; pkt_valid = pv; data_in = din; fifo_empty_vec = e; fifo_full_vec = f;
    low_pkt_valid = lo; parity_done = pd; read_enb_vec = rd;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [NUM_CH-1:0] e, f, rd;
    int                pulses;

    rst = 1'b1; pkt_valid = 1'b0; parity_done = 1'b0; low_pkt_valid = 1'b0;
    data_in = '0; fifo_full_vec = '0; fifo_empty_vec = '1; read_enb_vec = '1;

    // Directed vectors: reset, normal packet, full stall, wait-till-empty, drop, parity-check stall, reset mid-stall.
    tbl.push_back(mk(1, 0, 0, 3'b111, 3'b000, 0, 0, P_IDLE,   3'b000));
    tbl.push_back(mk(1, 0, 0, 3'b111, 3'b000, 0, 0, P_IDLE,   3'b000));
    tbl.push_back(mk(0, 1, 1, 3'b010, 3'b000, 0, 0, P_FIRST,  3'b010));
    tbl.push_back(mk(0, 1, 1, 3'b010, 3'b000, 0, 0, P_BODY,   3'b010));
    tbl.push_back(mk(0, 1, 1, 3'b010, 3'b000, 0, 0, P_BODY,   3'b010));
    tbl.push_back(mk(0, 0, 1, 3'b010, 3'b000, 0, 0, P_PARITY, 3'b010));
    tbl.push_back(mk(0, 0, 1, 3'b010, 3'b000, 0, 0, P_CHECK,  3'b000));
    tbl.push_back(mk(0, 0, 1, 3'b010, 3'b000, 0, 0, P_IDLE,   3'b000));
    tbl.push_back(mk(0, 1, 2, 3'b111, 3'b000, 0, 0, P_FIRST,  3'b100));
    tbl.push_back(mk(0, 1, 2, 3'b111, 3'b000, 0, 0, P_BODY,   3'b100));
    tbl.push_back(mk(0, 1, 2, 3'b111, 3'b100, 0, 0, P_STALL,  3'b000));
    tbl.push_back(mk(0, 1, 2, 3'b111, 3'b100, 0, 0, P_STALL,  3'b000));
    tbl.push_back(mk(0, 1, 2, 3'b111, 3'b100, 0, 0, P_STALL,  3'b000));
    tbl.push_back(mk(0, 0, 2, 3'b111, 3'b000, 0, 0, P_RESUME, 3'b100));
    tbl.push_back(mk(0, 0, 2, 3'b111, 3'b000, 1, 0, P_PARITY, 3'b100));
    tbl.push_back(mk(0, 0, 2, 3'b111, 3'b000, 0, 0, P_CHECK,  3'b000));
    tbl.push_back(mk(0, 0, 2, 3'b111, 3'b000, 0, 0, P_IDLE,   3'b000));
    tbl.push_back(mk(0, 1, 0, 3'b110, 3'b000, 0, 0, P_WAIT,   3'b000));
    tbl.push_back(mk(0, 1, 0, 3'b110, 3'b000, 0, 0, P_WAIT,   3'b000));
    tbl.push_back(mk(0, 1, 0, 3'b111, 3'b000, 0, 0, P_FIRST,  3'b001));
    tbl.push_back(mk(0, 1, 0, 3'b111, 3'b000, 0, 0, P_BODY,   3'b001));
    tbl.push_back(mk(0, 0, 0, 3'b111, 3'b000, 0, 0, P_PARITY, 3'b001));
    tbl.push_back(mk(0, 0, 0, 3'b111, 3'b000, 0, 0, P_CHECK,  3'b000));
    tbl.push_back(mk(0, 0, 0, 3'b111, 3'b000, 0, 0, P_IDLE,   3'b000));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 1, 3, 3'b111, 3'b000, 0, 0, P_DROP, 3'b000));
    tbl.push_back(mk(0, 0, 3, 3'b111, 3'b000, 0, 0, P_IDLE,   3'b000));
    tbl.push_back(mk(0, 1, 1, 3'b111, 3'b000, 0, 0, P_FIRST,  3'b010));
    tbl.push_back(mk(0, 0, 1, 3'b111, 3'b000, 0, 0, P_BODY,   3'b010));
    tbl.push_back(mk(0, 0, 1, 3'b111, 3'b000, 0, 0, P_PARITY, 3'b010));
    tbl.push_back(mk(0, 0, 1, 3'b111, 3'b010, 0, 0, P_CHECK,  3'b000));
    tbl.push_back(mk(0, 0, 1, 3'b111, 3'b010, 0, 0, P_STALL,  3'b000));
    tbl.push_back(mk(0, 0, 1, 3'b111, 3'b000, 0, 0, P_RESUME, 3'b010));
    tbl.push_back(mk(0, 0, 1, 3'b111, 3'b000, 0, 1, P_IDLE,   3'b000));
    tbl.push_back(mk(0, 1, 2, 3'b111, 3'b000, 0, 0, P_FIRST,  3'b100));
    tbl.push_back(mk(0, 1, 2, 3'b111, 3'b000, 0, 0, P_BODY,   3'b100));
    tbl.push_back(mk(0, 1, 2, 3'b111, 3'b100, 0, 0, P_STALL,  3'b000));
    tbl.push_back(mk(1, 1, 2, 3'b111, 3'b100, 0, 0, P_IDLE,   3'b000));

    foreach (tbl[k]) begin
      applyStimulus(tbl[k].r, tbl[k].pv, tbl[k].din, tbl[k].empty, tbl[k].full,
                    tbl[k].low, tbl[k].pdone, 3'b111, "tbl");
      checkValue($sformatf("tbl%0d_flags", k),
                 32'({busy, drop_state, rst_int_reg, write_enb_reg, full_state,
                      laf_state, ld_state, lfd_state, detect_addr}),
                 32'(flagsOf(tbl[k].exp_phase)));
      checkValue($sformatf("tbl%0d_write_enb", k), 32'(write_enb), 32'(tbl[k].exp_we));
    end

    // Channel 1 non-empty and unread: exactly one pulse, TIMEOUT cycles after the first unread cycle.
    pulses = 0;
    for (int k = 1; k <= TIMEOUT + 5; k++) begin
      applyStimulus(0, 0, 0, 3'b101, 3'b000, 0, 0, 3'b000, "tmo");
      checkValue($sformatf("tmo_pulse_c%0d", k), 32'(soft_reset),
                 (k == TIMEOUT) ? 32'h2 : 32'h0);
      if (soft_reset[1] === 1'b1) pulses++;
    end
    checkValue("tmo_pulse_count", 32'(pulses), 32'd1);

    // A read just before the limit restarts the count, so no pulse appears.
    applyStimulus(0, 0, 0, 3'b101, 3'b000, 0, 0, 3'b111, "tmo_clr");
    for (int k = 0; k < TIMEOUT + 6; k++) begin
      applyStimulus(0, 0, 0, 3'b101, 3'b000, 0, 0, (k == TIMEOUT - 1) ? 3'b010 : 3'b000, "tmo_rd");
      checkValue($sformatf("tmo_rd_nopulse_c%0d", k), 32'(soft_reset), 32'h0);
    end

    // Soft reset of the selected channel aborts a packet mid-load on the following cycle.
    applyStimulus(0, 0, 0, 3'b111, 3'b000, 0, 0, 3'b111, "tmo_fsm");
    applyStimulus(0, 1, 1, 3'b111, 3'b000, 0, 0, 3'b111, "tmo_fsm");
    checkValue("tmo_fsm_lfd", 32'(lfd_state), 32'd1);
    for (int k = 1; k <= TIMEOUT + 1; k++) begin
      applyStimulus(0, 1, 1, 3'b101, 3'b000, 0, 0, 3'b000, "tmo_fsm");
      if (k <= TIMEOUT) checkValue($sformatf("tmo_fsm_ld_c%0d", k), 32'(ld_state), 32'd1);
      if (k == TIMEOUT) checkValue("tmo_fsm_pulse", 32'(soft_reset), 32'h2);
      if (k == TIMEOUT + 1) begin
        checkValue("tmo_fsm_abort_detect", 32'(detect_addr), 32'd1);
        checkValue("tmo_fsm_abort_we", 32'(write_enb), 32'h0);
      end
    end

    // Randomized traffic against the model.
    applyStimulus(1, 0, 0, 3'b111, 3'b000, 0, 0, 3'b111, "rnd_rst");
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        e[i]  = ($urandom_range(0, 3) != 0);
        f[i]  = ($urandom_range(0, 3) == 0);
        rd[i] = ($urandom_range(0, 7) == 0);
      end
      if (k % 200 > 100) e = 3'b000;
      applyStimulus(($urandom_range(0, 127) == 0), ($urandom_range(0, 9) < 7),
                    ADDR_W'($urandom_range(0, 3)), e, f,
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), rd, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_fsm_nch.md
Name: router_fsm_nch

Overview:
Parametrised successor to the 1x3 router control FSM. It steers a byte-serial packet (header carries the destination address) into one of NUM_CH output FIFOs. It sequences header, payload and parity loads, and stalls on FIFO-full. New over the fixed 1x3 version: it drops packets addressed to a nonexistent channel, and it integrates per-channel soft-reset timeout counters. Sits between the input register and the FIFO bank, replacing both the fixed FSM and the external timeout logic.

Parameters:
NUM_CH, 3, number of output channels/FIFOs (1..2**ADDR_W)
ADDR_W, 2, header address field width (data_in LSBs)
TIMEOUT, 30, idle cycles a non-empty output FIFO may go unread before its soft reset fires (>=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
pkt_valid  in  1  packet byte stream valid (high during header+payload, low on parity byte)
parity_done  in  1  parity byte has been written
low_pkt_valid  in  1  pkt_valid fell while stalled (from register block)
data_in  in  ADDR_W  address field of current byte (sampled in DECODE_ADDRESS only)
fifo_full_vec  in  NUM_CH  per-FIFO full
fifo_empty_vec  in  NUM_CH  per-FIFO empty
read_enb_vec  in  NUM_CH  per-channel read strobe from the output side
busy  out  1  stall to source
detect_addr, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, drop_state  out  1 each  state decodes
write_enb  out  NUM_CH  one-hot write enable to the selected FIFO
soft_reset  out  NUM_CH  one-cycle per-channel soft-reset pulse

Behaviour:
- States: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR, DROP_PACKET.
- Reset: state = DECODE_ADDRESS, sel = 0, all counters = 0, soft_reset = 0. Outputs therefore: detect_addr = 1, all others 0.
- sel register:
  - Loaded from data_in when state = DECODE_ADDRESS and pkt_valid = 1 and data_in < NUM_CH.
  - Otherwise holds its value.
  - full = fifo_full_vec[sel]; empty_sel = fifo_empty_vec[sel].
- Transitions, evaluated in priority order:
  - rst forces DECODE_ADDRESS.
  - soft_reset[sel] = 1 while state != DECODE_ADDRESS forces DECODE_ADDRESS.
  - Otherwise, per state:
    - DECODE_ADDRESS:
      - pkt_valid & data_in >= NUM_CH -> DROP_PACKET
      - pkt_valid & fifo_empty_vec[data_in] -> LOAD_FIRST_DATA
      - pkt_valid & !fifo_empty_vec[data_in] -> WAIT_TILL_EMPTY
      - else stay
    - LOAD_FIRST_DATA -> LOAD_DATA.
    - LOAD_DATA: full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay.
    - FIFO_FULL_STATE: full -> stay; else -> LOAD_AFTER_FULL.
    - LOAD_AFTER_FULL:
      - parity_done -> DECODE_ADDRESS
      - low_pkt_valid -> LOAD_PARITY
      - else -> LOAD_DATA
    - LOAD_PARITY -> CHECK_PARITY_ERROR.
    - CHECK_PARITY_ERROR: full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
    - WAIT_TILL_EMPTY: empty_sel -> LOAD_FIRST_DATA; else stay.
    - DROP_PACKET: !pkt_valid -> DECODE_ADDRESS; else stay. Nothing is written in this state.
- Moore outputs, combinational from state only:
  - detect_addr = DECODE_ADDRESS
  - lfd_state = LOAD_FIRST_DATA
  - ld_state = LOAD_DATA
  - laf_state = LOAD_AFTER_FULL
  - full_state = FIFO_FULL_STATE
  - rst_int_reg = CHECK_PARITY_ERROR
  - drop_state = DROP_PACKET
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL
  - busy = LOAD_FIRST_DATA | LOAD_PARITY | FIFO_FULL_STATE | LOAD_AFTER_FULL | WAIT_TILL_EMPTY | CHECK_PARITY_ERROR
  - busy = 0 in DECODE_ADDRESS, LOAD_DATA and DROP_PACKET.
- write_enb = (write_enb_reg | lfd_state) ? one-hot(sel) : 0. It is never asserted in DROP_PACKET or DECODE_ADDRESS.
- Timeout, one counter per channel i, width $clog2(TIMEOUT):
  - Clears when fifo_empty_vec[i] or read_enb_vec[i] is 1.
  - Otherwise increments.
  - When the counter = TIMEOUT-1 and the increment condition holds, soft_reset[i] = 1 on the next cycle, for exactly one cycle, and the counter clears. It resumes counting the cycle after.
  - Therefore the pulse is registered and appears TIMEOUT cycles after the first unread non-empty cycle.
  - Counters run in every FSM state, independently of the FSM.
- Simultaneous events:
  - soft_reset for a channel other than sel does not affect the FSM.
  - rst mid-packet aborts immediately. No write_enb the following cycle.

Decomposition:
- router_pkg: state enum (9 states, 4-bit encoding), localparam for counter width.
- Sub-module router_timeout_ctr (params TIMEOUT; ports clk, rst, empty, read_enb, soft_reset), instantiated NUM_CH times via generate.

Test Plan:
1. NUM_CH=3. rst 2 cycles, then pkt_valid=1, data_in=1, fifo_empty_vec=3'b010. Drop pkt_valid after 2 cycles -> states DECODE, LFD, LD, LD, LOAD_PARITY, CPE, DECODE. write_enb=3'b010 for 4 cycles. busy=1 in LFD, LOAD_PARITY and CPE.
2. data_in=2, packet in progress, fifo_full_vec[2]=1 for 3 cycles while in LD -> FIFO_FULL_STATE held 3 cycles with busy=1, write_enb=0. Then LAF; low_pkt_valid=1 -> LOAD_PARITY.
3. data_in=0 with fifo_empty_vec[0]=0 -> WAIT_TILL_EMPTY, busy=1. Empty rises -> LFD next cycle with write_enb=3'b001.
4. data_in=3 with NUM_CH=3, pkt_valid held 5 cycles -> DROP_PACKET, drop_state=1, write_enb=0 throughout. Back to DECODE the cycle after pkt_valid falls.
5. fifo_empty_vec[1]=0, read_enb_vec=0 for 30 cycles -> soft_reset[1] pulses exactly once, 30 cycles after the start. If sel=1 mid-LD, the FSM goes to DECODE next cycle. A read_enb at cycle 29 instead -> no pulse.
6. rst asserted during FIFO_FULL_STATE -> next cycle DECODE, detect_addr=1, all other outputs and counters 0.
